// File: rtl/router_pkg.sv
// Shared router types: flit header layout, output port indices and one-hot port type.
package router_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_COORD_BITS = 3;

  // Type occupies the top TYPE_BITS of a flit; dest_x and dest_y follow directly below it.
  localparam int unsigned TYPE_BITS = 2;

  typedef enum logic [TYPE_BITS-1:0] {
    FT_BODY     = 2'b00,
    FT_TAIL     = 2'b01,
    FT_HEAD     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_t;

  localparam int unsigned PORT_LOCAL = 0;
  localparam int unsigned PORT_NORTH = 1;
  localparam int unsigned PORT_EAST  = 2;
  localparam int unsigned PORT_SOUTH = 3;
  localparam int unsigned PORT_WEST  = 4;
  localparam int unsigned NUM_PORTS  = 5;

  typedef logic [NUM_PORTS-1:0] port_onehot_t;

  function automatic port_onehot_t port_oh(input int unsigned idx);
    return port_onehot_t'(1) << idx;
  endfunction

endpackage

// File: rtl/route_fn.sv
// West-first partially adaptive output-port selection; purely combinational.
module route_fn
  import router_pkg::*;
#(
  parameter int unsigned COORD_BITS = 3,
  parameter int unsigned X_POS      = 0,
  parameter int unsigned Y_POS      = 0
) (
  input  logic [COORD_BITS-1:0] dest_x_i,
  input  logic [COORD_BITS-1:0] dest_y_i,
  input  port_onehot_t          credit_ok_i,
  output port_onehot_t          route_c_o
);

  localparam logic [COORD_BITS:0] X_EXT = (COORD_BITS+1)'(X_POS);
  localparam logic [COORD_BITS:0] Y_EXT = (COORD_BITS+1)'(Y_POS);

  logic [COORD_BITS:0] dx_diff;
  logic [COORD_BITS:0] dy_diff;
  logic                x_lt, x_eq, y_lt, y_eq;
  port_onehot_t        vert_oh;

  // Widened subtraction gives the unsigned compares without constant-range compares at origin.
  assign dx_diff = {1'b0, dest_x_i} - X_EXT;
  assign dy_diff = {1'b0, dest_y_i} - Y_EXT;
  assign x_lt    = dx_diff[COORD_BITS];
  assign x_eq    = (dx_diff == '0);
  assign y_lt    = dy_diff[COORD_BITS];
  assign y_eq    = (dy_diff == '0);

  always_comb begin
    route_c_o = port_oh(PORT_LOCAL);
    vert_oh   = y_lt ? port_oh(PORT_SOUTH) : port_oh(PORT_NORTH);
    if (x_lt) begin
      route_c_o = port_oh(PORT_WEST);
    end else if (x_eq) begin
      if (!y_eq) route_c_o = vert_oh;
    end else if (y_eq || credit_ok_i[PORT_EAST]) begin
      route_c_o = port_oh(PORT_EAST);
    end else if (|(credit_ok_i & vert_oh)) begin
      route_c_o = vert_oh;
    end else begin
      route_c_o = port_oh(PORT_EAST);
    end
  end

endmodule

// File: rtl/route_compute.sv
// Input-port route stage: routes each packet head once, locks the port for the
// wormhole and forwards flits from the FIFO head to the switch allocator.
module route_compute
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned COORD_BITS = DEF_COORD_BITS,
  parameter int unsigned X_POS      = 0,
  parameter int unsigned Y_POS      = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_pop,
  input  port_onehot_t          credit_ok,
  output logic                  sa_req,
  output port_onehot_t          sa_port,
  output logic [DATA_WIDTH-1:0] sa_flit,
  input  logic                  sa_gnt,
  output logic                  err
);

  localparam int unsigned TYPE_LSB = DATA_WIDTH - TYPE_BITS;
  localparam int unsigned X_LSB    = TYPE_LSB - COORD_BITS;
  localparam int unsigned Y_LSB    = X_LSB - COORD_BITS;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e       state_q, state_d;
  port_onehot_t route_q, route_d;
  port_onehot_t route_c;
  flit_type_t   head_type;
  logic         is_head, is_last;

  assign head_type = flit_type_t'(fifo_dout[TYPE_LSB +: TYPE_BITS]);
  assign is_head   = (head_type == FT_HEAD) || (head_type == FT_HEADTAIL);
  assign is_last   = (head_type == FT_TAIL) || (head_type == FT_HEADTAIL);

  route_fn #(
    .COORD_BITS (COORD_BITS),
    .X_POS      (X_POS),
    .Y_POS      (Y_POS)
  ) u_route_fn (
    .dest_x_i    (fifo_dout[X_LSB +: COORD_BITS]),
    .dest_y_i    (fifo_dout[Y_LSB +: COORD_BITS]),
    .credit_ok_i (credit_ok),
    .route_c_o   (route_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Pop, request and error follow the FIFO head in the same cycle.
  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    fifo_pop = 1'b0;
    sa_req   = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (is_head) begin
            route_d = route_c;
            state_d = S_ACTIVE;
          end else begin
            fifo_pop = 1'b1;
            err      = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        sa_req = !fifo_empty;
        if (sa_req && sa_gnt) begin
          fifo_pop = 1'b1;
          err      = (head_type == FT_HEAD);
          if (is_last) begin
            state_d = S_IDLE;
            route_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sa_port = route_q;
  assign sa_flit = fifo_dout;

endmodule

// File: tb/tb_route_compute.sv
// Randomized and directed bench for route_compute at router (2,2) against a packet-level model.
module tb_route_compute;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_pop;
  logic [4:0]  credit_ok;
  logic        sa_req;
  logic [4:0]  sa_port;
  logic [31:0] sa_flit;
  logic        sa_gnt;
  logic        err;

  route_compute #(
    .DATA_WIDTH (32),
    .COORD_BITS (3),
    .X_POS      (2),
    .Y_POS      (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .credit_ok  (credit_ok),
    .sa_req     (sa_req),
    .sa_port    (sa_port),
    .sa_flit    (sa_flit),
    .sa_gnt     (sa_gnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] BODY = 2'b00, TAIL = 2'b01, HEAD = 2'b10, HT = 2'b11;
  localparam logic [4:0] P_L = 5'b00001, P_N = 5'b00010, P_E = 5'b00100,
                         P_S = 5'b01000, P_W = 5'b10000;

  logic [31:0] q[$];
  bit          in_pkt;
  logic [4:0]  cur_route;
  int          n_cmp, n_bad;
  int          pop_cnt, err_cnt, req_cnt;
  logic [4:0]  first_port, last_port;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // West-first rule for router (2,2).
  function automatic logic [4:0] ref_route(input int x, input int y, input logic [4:0] c);
    logic [4:0] vert;
    if (x < 2) return P_W;
    if (x == 2) return (y > 2) ? P_N : (y < 2) ? P_S : P_L;
    if (y == 2) return P_E;
    vert = (y > 2) ? P_N : P_S;
    if (c[2]) return P_E;
    if ((c & vert) != 0) return vert;
    return P_E;
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] ty, input logic [2:0] x, input logic [2:0] y);
    return {ty, x, y, 24'($urandom)};
  endfunction

  task automatic clr_counts();
    pop_cnt = 0; err_cnt = 0; req_cnt = 0; first_port = '0; last_port = '0;
  endtask

  task automatic run_cycle(input bit do_push, input logic [31:0] f, input logic [4:0] c, input bit g);
    bit          emp;
    logic [31:0] h;
    logic [1:0]  ty;
    bit          exp_req, exp_pop, exp_err, nxt_in;
    logic [4:0]  exp_port, nxt_route;
    if (do_push) q.push_back(f);
    emp        = (q.size() == 0);
    h          = emp ? 32'($urandom) : q[0];
    credit_ok  = c;
    sa_gnt     = g;
    fifo_empty = emp;
    fifo_dout  = h;
    @(negedge clk);
    ty        = h[31:30];
    exp_port  = in_pkt ? cur_route : 5'b0;
    exp_req   = in_pkt && !emp;
    exp_pop   = 1'b0;
    exp_err   = 1'b0;
    nxt_in    = in_pkt;
    nxt_route = cur_route;
    if (!emp) begin
      if (!in_pkt) begin
        if (ty == HEAD || ty == HT) begin
          nxt_in    = 1'b1;
          nxt_route = ref_route(int'(h[29:27]), int'(h[26:24]), c);
        end else begin
          exp_pop = 1'b1;
          exp_err = 1'b1;
        end
      end else if (g) begin
        exp_pop = 1'b1;
        exp_err = (ty == HEAD);
        if (ty == TAIL || ty == HT) begin
          nxt_in    = 1'b0;
          nxt_route = '0;
        end
      end
    end
    chk_eq("sa_req", 32'(sa_req), 32'(exp_req));
    chk_eq("sa_port", 32'(sa_port), 32'(exp_port));
    chk_eq("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    chk_eq("err", 32'(err), 32'(exp_err));
    if (!emp) chk_eq("sa_flit", sa_flit, h);
    if (fifo_pop) pop_cnt++;
    if (err) err_cnt++;
    if (sa_req) begin
      if (req_cnt == 0) first_port = sa_port;
      last_port = sa_port;
      req_cnt++;
    end
    if (fifo_pop && q.size() > 0) void'(q.pop_front());
    in_pkt    = nxt_in;
    cur_route = nxt_route;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0, 5'h1f, 1'b0);
  endtask

  // One cycle of reset with the FIFO empty; outputs must already be quiet.
  task automatic reset_cycle();
    reset_n    = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = 32'($urandom);
    sa_gnt     = 1'b1;
    credit_ok  = 5'h1f;
    @(negedge clk);
    chk_eq("rst_sa_req", 32'(sa_req), 32'd0);
    chk_eq("rst_sa_port", 32'(sa_port), 32'd0);
    chk_eq("rst_fifo_pop", 32'(fifo_pop), 32'd0);
    chk_eq("rst_err", 32'(err), 32'd0);
    in_pkt    = 1'b0;
    cur_route = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         gen_in, p;
    logic [1:0] ty;
    n_cmp = 0; n_bad = 0;
    in_pkt = 1'b0; cur_route = '0;
    reset_n = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; credit_ok = '0; sa_gnt = 1'b0;
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    reset_cycle();
    idle(2);

    // Single-flit packet heading west.
    clr_counts();
    run_cycle(1'b1, mk(HT, 3'd0, 3'd3), 5'h1f, 1'b1);
    run_cycle(1'b0, 32'h0, 5'h1f, 1'b1);
    idle(2);
    chk_eq("s1_port", 32'(first_port), 32'(P_W));
    chk_eq("s1_pops", 32'(pop_cnt), 32'd1);
    chk_eq("s1_reqs", 32'(req_cnt), 32'd1);

    // Adaptive choice made at the head and held after credits change.
    clr_counts();
    run_cycle(1'b1, mk(HEAD, 3'd4, 3'd0), 5'b01011, 1'b1);
    run_cycle(1'b1, mk(BODY, 3'd0, 3'd0), 5'b11111, 1'b1);
    run_cycle(1'b1, mk(TAIL, 3'd0, 3'd0), 5'b11111, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 32'h0, 5'b11111, 1'b1);
    chk_eq("s2_first_port", 32'(first_port), 32'(P_S));
    chk_eq("s2_tail_port", 32'(last_port), 32'(P_S));
    chk_eq("s2_pops", 32'(pop_cnt), 32'd3);

    // Local delivery with grant withheld two cycles per flit.
    clr_counts();
    run_cycle(1'b1, mk(HEAD, 3'd2, 3'd2), 5'h1f, 1'b0);
    run_cycle(1'b1, mk(BODY, 3'd5, 3'd5), 5'h1f, 1'b0);
    run_cycle(1'b1, mk(TAIL, 3'd1, 3'd1), 5'h1f, 1'b1);
    for (int i = 3; i < 12; i++) run_cycle(1'b0, 32'h0, 5'h1f, (i % 3) == 2);
    chk_eq("s3_pops", 32'(pop_cnt), 32'd3);
    chk_eq("s3_port", 32'(last_port), 32'(P_L));
    idle(2);

    // Stray body flit while idle.
    clr_counts();
    run_cycle(1'b1, mk(BODY, 3'd3, 3'd3), 5'h1f, 1'b1);
    idle(2);
    chk_eq("s4_errs", 32'(err_cnt), 32'd1);
    chk_eq("s4_pops", 32'(pop_cnt), 32'd1);
    chk_eq("s4_reqs", 32'(req_cnt), 32'd0);

    // FIFO runs dry mid-packet.
    clr_counts();
    run_cycle(1'b1, mk(HEAD, 3'd3, 3'd2), 5'h1f, 1'b1);
    run_cycle(1'b0, 32'h0, 5'h1f, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'h0, 5'h00, 1'b1);
    run_cycle(1'b1, mk(TAIL, 3'd0, 3'd0), 5'h00, 1'b1);
    idle(2);
    chk_eq("s5_port", 32'(last_port), 32'(P_E));
    chk_eq("s5_reqs", 32'(req_cnt), 32'd2);
    chk_eq("s5_pops", 32'(pop_cnt), 32'd2);

    // Reset mid-packet; leftover flits are dropped.
    run_cycle(1'b1, mk(HEAD, 3'd1, 3'd1), 5'h1f, 1'b1);
    run_cycle(1'b0, 32'h0, 5'h1f, 1'b1);
    reset_cycle();
    clr_counts();
    run_cycle(1'b1, mk(BODY, 3'd0, 3'd0), 5'h1f, 1'b1);
    run_cycle(1'b1, mk(TAIL, 3'd0, 3'd0), 5'h1f, 1'b1);
    idle(2);
    chk_eq("s6_errs", 32'(err_cnt), 32'd2);
    chk_eq("s6_pops", 32'(pop_cnt), 32'd2);
    chk_eq("s6_reqs", 32'(req_cnt), 32'd0);

    // Random traffic, mostly well-formed with occasional stray types.
    gen_in = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 99) < 45) && (q.size() < 8);
      if ($urandom_range(0, 19) == 0) ty = 2'($urandom_range(0, 3));
      else if (!gen_in) ty = ($urandom_range(0, 3) == 0) ? HT : HEAD;
      else ty = ($urandom_range(0, 2) == 0) ? TAIL : BODY;
      if (p) begin
        if (ty == HEAD) gen_in = 1'b1;
        else if (ty == TAIL || ty == HT) gen_in = 1'b0;
      end
      run_cycle(p, mk(ty, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))),
                5'($urandom), ($urandom_range(0, 99) < 60));
    end

    for (int i = 0; i < 300 && q.size() > 0; i++)
      run_cycle(1'b0, 32'h0, 5'($urandom), 1'b1);
    chk_eq("drain", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
